// File: rtl/ps2_pkg.sv
// ps2_pkg: shared frame states, key event layout and PS/2 byte constants
package ps2_pkg;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;
   typedef struct packed {
      logic       brk;
      logic       ext;
      logic [7:0] code;
   } key_event_t;
   localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
   localparam logic [7:0] PS2_ERR_00  = 8'h00;
   localparam logic [7:0] PS2_ERR_FF  = 8'hFF;
endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: pin sync, ps2_clk glitch filter, 11-bit frame FSM, optional watchdog (PS2_TIMEOUT_EN)
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err,
   output logic       frame_tmo
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   logic [1:0]    clk_s, dat_s;
   logic [FW-1:0] fcnt;
   logic          filt, filt_d, strobe, par;
   logic [2:0]    n;
   logic [7:0]    sh;
   frame_state_t  state;
   assign strobe = filt_d & ~filt;
   // synchronise pins; filtered clock flips only after FILTER_LEN differing samples in a row
   always_ff @(posedge CLOCK_50 or negedge reset)
      if (!reset) begin
         clk_s  <= 2'b11;
         dat_s  <= 2'b11;
         fcnt   <= '0;
         filt   <= 1'b1;
         filt_d <= 1'b1;
      end else begin
         clk_s  <= {clk_s[0], ps2_clk};
         dat_s  <= {dat_s[0], ps2_data};
         filt_d <= filt;
         if (clk_s[1] == filt)
            fcnt <= '0;
         else if (fcnt == FW'(FILTER_LEN - 1)) begin
            filt <= clk_s[1];
            fcnt <= '0;
         end else
            fcnt <= fcnt + 1'b1;
      end
`ifdef PS2_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tcnt;
`else
   assign frame_tmo = 1'b0;
`endif
   // frame FSM: start, 8 data LSB first, odd parity, stop; watchdog abandons stalled frames
   always_ff @(posedge CLOCK_50 or negedge reset)
      if (!reset) begin
         state      <= IDLE;
         n          <= '0;
         sh         <= '0;
         par        <= 1'b0;
         rx_byte    <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
`ifdef PS2_TIMEOUT_EN
         tcnt       <= '0;
         frame_tmo  <= 1'b0;
`endif
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (strobe)
            case (state)
               IDLE:   if (!dat_s[1]) begin
                          state <= DATA;
                          n     <= '0;
                       end
               DATA:   begin
                          sh    <= {dat_s[1], sh[7:1]};
                          n     <= n + 1'b1;
                          state <= n == 3'd7 ? PARITY : DATA;
                       end
               PARITY: begin
                          par   <= dat_s[1];
                          state <= STOP;
                       end
               default: begin
                          rx_byte    <= sh;
                          byte_valid <= dat_s[1] & (^sh ^ par);
                          frame_err  <= ~(dat_s[1] & (^sh ^ par));
                          state      <= IDLE;
                       end
            endcase
`ifdef PS2_TIMEOUT_EN
         frame_tmo <= 1'b0;
         if (state == IDLE || strobe)
            tcnt <= '0;
         else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            tcnt      <= '0;
            state     <= IDLE;
            frame_tmo <= 1'b1;
         end else
            tcnt <= tcnt + 1'b1;
`endif
      end
endmodule

// File: rtl/ps2_key_controller.sv
// ps2_key_controller: PS/2 key events with E0/F0 folding, event FIFO and CPU IO view (watchdog via PS2_TIMEOUT_EN)
module ps2_key_controller
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   input  logic        io_read,
   output logic [15:0] io_rdata,
   output logic        io_irq,
   output logic [7:0]  err_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [7:0]  rx_byte;
   logic        byte_valid, frame_err, frame_tmo;
   logic        ext, brk, ovf, ovf_n, is_ext, is_brk, is_bad, push, pop, wr, full, nonempty_n, err_inc;
   logic [AW-1:0] wp, rp, rp_n;
   logic [AW:0] cnt, cnt_n, rem;
   key_event_t  ev, head_n;
   key_event_t  mem [FIFO_DEPTH];
   ps2_rx_frame #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rx_byte   (rx_byte),
      .byte_valid(byte_valid),
      .frame_err (frame_err),
      .frame_tmo (frame_tmo)
   );
   // classify bytes, FIFO next state; head view bypasses a push into an emptying FIFO
   always_comb begin
      is_ext     = rx_byte == PS2_PFX_EXT;
      is_brk     = rx_byte == PS2_PFX_BRK;
      is_bad     = rx_byte == PS2_ERR_00 || rx_byte == PS2_ERR_FF;
      push       = byte_valid & ~is_ext & ~is_brk & ~is_bad;
      ev         = key_event_t'{brk: brk, ext: ext, code: rx_byte};
      full       = cnt == (AW+1)'(FIFO_DEPTH);
      pop        = io_read & (cnt != '0);
      wr         = push & (~full | pop);
      cnt_n      = cnt + (AW+1)'(wr) - (AW+1)'(pop);
      rem        = cnt - (AW+1)'(pop);
      rp_n       = rp + AW'(pop);
      head_n     = rem != '0 ? mem[rp_n] : ev;
      ovf_n      = io_read ? 1'b0 : (push & full) ? 1'b1 : ovf;
      nonempty_n = cnt_n != '0;
      err_inc    = frame_err | frame_tmo | (byte_valid & is_bad);
   end
   // event storage
   always_ff @(posedge CLOCK_50)
      if (wr) mem[wp] <= ev;
   // pointers, prefixes, error counter and registered IO view
   always_ff @(posedge CLOCK_50 or negedge reset)
      if (!reset) begin
         wp        <= '0;
         rp        <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         ext       <= 1'b0;
         brk       <= 1'b0;
         err_count <= '0;
         io_irq    <= 1'b0;
         io_rdata  <= '0;
      end else begin
         wp        <= wp + AW'(wr);
         rp        <= rp_n;
         cnt       <= cnt_n;
         ovf       <= ovf_n;
         io_irq    <= nonempty_n;
         io_rdata  <= {nonempty_n, ovf_n, 4'b0, nonempty_n ? head_n : key_event_t'('0)};
         err_count <= err_inc && err_count != 8'hFF ? err_count + 1'b1 : err_count;
         if (frame_tmo) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end else if (byte_valid) begin
            ext <= is_ext | (ext & is_brk);
            brk <= is_brk | (brk & is_ext);
         end
      end
endmodule

// File: tb/tb_ps2_key_controller.sv
// tb_ps2_key_controller: directed PS/2 frames with hand-computed IO bus expectations
module tb_ps2_key_controller;
   localparam int TMO = 2000;
   logic        CLOCK_50 = 1'b0, reset = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, io_read = 1'b0;
   logic [15:0] io_rdata;
   logic        io_irq;
   logic [7:0]  err_count;
   int          total = 0, bad = 0;
   ps2_key_controller #(.FIFO_DEPTH(8), .FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .io_read  (io_read),
      .io_rdata (io_rdata),
      .io_irq   (io_irq),
      .err_count(err_count)
   );
   always #5 CLOCK_50 = ~CLOCK_50;
   task automatic cyc(input int k);
      repeat (k) @(negedge CLOCK_50);
   endtask
   function automatic logic [10:0] frame(input logic [7:0] b, input logic flip);
      return {1'b1, ~^b ^ flip, b, 1'b0};
   endfunction
   task automatic send_bits(input logic [10:0] f, input int n, input int glitch);
      for (int i = 0; i < n; i++) begin
         ps2_data = f[i];
         cyc(10);
         ps2_clk = 1'b0;
         cyc(20);
         ps2_clk = 1'b1;
         if (i == glitch) begin
            cyc(3);
            ps2_clk = 1'b0;
            cyc(2);
            ps2_clk = 1'b1;
            cyc(5);
         end else
            cyc(10);
      end
      ps2_data = 1'b1;
   endtask
   task automatic send(input logic [7:0] b);
      send_bits(frame(b, 1'b0), 11, -1);
      cyc(5);
   endtask
   task automatic pop_one;
      io_read = 1'b1;
      cyc(1);
      io_read = 1'b0;
      cyc(2);
   endtask
   task automatic test_reset;
      cyc(3);
      total++; if (io_rdata !== 16'h0000) begin $display("FAIL reset_rdata: got %h want 0000", io_rdata); bad++; end
      total++; if (io_irq !== 1'b0) begin $display("FAIL reset_irq: got %b want 0", io_irq); bad++; end
      total++; if (err_count !== 8'h00) begin $display("FAIL reset_err: got %h want 00", err_count); bad++; end
      reset = 1'b1;
      cyc(3);
   endtask
   task automatic test_make;
      send(8'h1C);
      total++; if (io_irq !== 1'b1) begin $display("FAIL make_irq: got %b want 1", io_irq); bad++; end
      total++; if (io_rdata !== 16'h801C) begin $display("FAIL make_rdata: got %h want 801c", io_rdata); bad++; end
      pop_one;
      total++; if (io_irq !== 1'b0) begin $display("FAIL make_pop_irq: got %b want 0", io_irq); bad++; end
      total++; if (io_rdata !== 16'h0000) begin $display("FAIL make_pop_rdata: got %h want 0000", io_rdata); bad++; end
   endtask
   task automatic test_ext_break;
      send(8'hE0);
      total++; if (io_irq !== 1'b0) begin $display("FAIL prefix_e0_irq: got %b want 0", io_irq); bad++; end
      send(8'hF0);
      total++; if (io_irq !== 1'b0) begin $display("FAIL prefix_f0_irq: got %b want 0", io_irq); bad++; end
      send(8'h75);
      total++; if (io_rdata !== 16'h8375) begin $display("FAIL ext_brk_rdata: got %h want 8375", io_rdata); bad++; end
      pop_one;
      total++; if (io_irq !== 1'b0) begin $display("FAIL ext_brk_single: got %b want 0", io_irq); bad++; end
   endtask
   task automatic test_parity;
      send_bits(frame(8'h1C, 1'b1), 11, -1);
      cyc(5);
      total++; if (io_irq !== 1'b0) begin $display("FAIL parity_irq: got %b want 0", io_irq); bad++; end
      total++; if (err_count !== 8'h01) begin $display("FAIL parity_err: got %h want 01", err_count); bad++; end
      send(8'h32);
      total++; if (io_rdata !== 16'h8032) begin $display("FAIL parity_next: got %h want 8032", io_rdata); bad++; end
      pop_one;
   endtask
   task automatic test_err_codes;
      send(8'h00);
      total++; if (err_count !== 8'h02) begin $display("FAIL code00_err: got %h want 02", err_count); bad++; end
      total++; if (io_irq !== 1'b0) begin $display("FAIL code00_irq: got %b want 0", io_irq); bad++; end
      send(8'hE0);
      send(8'hFF);
      send(8'h1C);
      total++; if (err_count !== 8'h03) begin $display("FAIL codeff_err: got %h want 03", err_count); bad++; end
      total++; if (io_rdata !== 16'h801C) begin $display("FAIL codeff_clears_pfx: got %h want 801c", io_rdata); bad++; end
      pop_one;
   endtask
   task automatic test_overflow;
      for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
      total++; if (io_rdata !== 16'hC010) begin $display("FAIL ovf_head: got %h want c010", io_rdata); bad++; end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (io_rdata !== ((i == 0 ? 16'hC000 : 16'h8000) | 16'(8'h10 + 8'(i)))) begin
            $display("FAIL ovf_drain_%0d: got %h want %h", i, io_rdata, (i == 0 ? 16'hC000 : 16'h8000) | 16'(8'h10 + 8'(i)));
            bad++;
         end
         pop_one;
      end
      total++; if (io_rdata !== 16'h0000) begin $display("FAIL ovf_empty_rdata: got %h want 0000", io_rdata); bad++; end
      total++; if (io_irq !== 1'b0) begin $display("FAIL ovf_empty_irq: got %b want 0", io_irq); bad++; end
   endtask
   task automatic test_back_to_back;
      send(8'h21);
      total++; if (io_irq !== 1'b1) begin $display("FAIL b2b_irq1: got %b want 1", io_irq); bad++; end
      send(8'h22);
      total++; if (io_rdata !== 16'h8021) begin $display("FAIL b2b_head: got %h want 8021", io_rdata); bad++; end
      pop_one;
      total++; if (io_rdata !== 16'h8022) begin $display("FAIL b2b_second: got %h want 8022", io_rdata); bad++; end
      total++; if (io_irq !== 1'b1) begin $display("FAIL b2b_irq2: got %b want 1", io_irq); bad++; end
      pop_one;
      total++; if (io_irq !== 1'b0) begin $display("FAIL b2b_irq_end: got %b want 0", io_irq); bad++; end
   endtask
   task automatic test_glitch;
      send_bits(frame(8'h1C, 1'b0), 11, 4);
      cyc(5);
      total++; if (io_rdata !== 16'h801C) begin $display("FAIL glitch_rdata: got %h want 801c", io_rdata); bad++; end
      pop_one;
   endtask
   task automatic test_timeout;
`ifdef PS2_TIMEOUT_EN
      send_bits(frame(8'h55, 1'b0), 5, -1);
      cyc(TMO + 100);
      total++; if (err_count !== 8'h04) begin $display("FAIL timeout_err: got %h want 04", err_count); bad++; end
      send(8'h1C);
      total++; if (io_rdata !== 16'h801C) begin $display("FAIL timeout_recover: got %h want 801c", io_rdata); bad++; end
      pop_one;
`endif
   endtask
   task automatic test_reset_mid;
      send(8'hE0);
      send_bits(frame(8'h1C, 1'b0), 4, -1);
      reset = 1'b0;
      cyc(2);
      total++; if (io_rdata !== 16'h0000) begin $display("FAIL rstmid_rdata: got %h want 0000", io_rdata); bad++; end
      total++; if (io_irq !== 1'b0) begin $display("FAIL rstmid_irq: got %b want 0", io_irq); bad++; end
      total++; if (err_count !== 8'h00) begin $display("FAIL rstmid_err: got %h want 00", err_count); bad++; end
      reset = 1'b1;
      cyc(5);
      send(8'h1C);
      total++; if (io_rdata !== 16'h801C) begin $display("FAIL rstmid_after: got %h want 801c", io_rdata); bad++; end
      pop_one;
   endtask
   initial begin
      test_reset;
      test_make;
      test_ext_break;
      test_parity;
      test_err_codes;
      test_overflow;
      test_back_to_back;
      test_glitch;
      test_timeout;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
